// File: rtl/su_adder_ambi_irrel.sv
// Spatial-unrolling reduction adder: sums psums of PEs mapped on an irrelevant
// loop dimension (possibly interleaved with a relevant one) into packed GBF lines.
module su_adder_ambi_irrel #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int DEPTH                 = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_BITWIDTH*ROW*COL-1:0]      psum_out,
  input  logic                                  pe_psum_finish,
  input  logic                                  conv_finish,
  input  logic [4:0]                            irrel_num,
  input  logic [4:0]                            rel_num,
  output logic [PSUM_RF_ADDR_BITWIDTH-1:0]      psum_rf_addr,
  output logic                                  su_add_finish,
  output logic [GBF_DATA_BITWIDTH-1:0]          out_data,
  output logic                                  psum_write_en,
  output logic [9:0]                            psum_BRAM_addr
);
  localparam int N  = ROW * COL;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = 20;
  localparam int DW = DATA_BITWIDTH;

  typedef enum logic [1:0] {IDLE, ACC, WRITE, DONE} state_t;
  state_t r_state, w_state_next;

  logic [4:0]                       r_i, r_r, r_j, r_m;
  logic [9:0]                       r_ir;
  logic [IW-1:0]                    r_jr, r_blk;
  logic [9:0]                       r_wp;
  logic [PSUM_RF_ADDR_BITWIDTH-1:0] r_rf_addr;

  logic [4:0]                 w_i_eff, w_r_eff;
  logic [9:0]                 w_start_ir;
  logic                       w_empty, w_last_j, w_start;
  logic                       w_acc_clr, w_acc_en;
  logic [DW-1:0]              w_psum  [N];
  logic [IW-1:0]              w_blk   [DEPTH+1];
  logic [4:0]                 w_m     [DEPTH+1];
  logic                       w_valid [DEPTH+1];
  logic [SW-1:0]              w_idx   [DEPTH];
  logic [DW-1:0]              w_word  [DEPTH];
  logic [GBF_DATA_BITWIDTH-1:0] w_line;

  assign w_i_eff    = (irrel_num == 5'd0) ? 5'd1 : irrel_num;
  assign w_r_eff    = (rel_num == 5'd0) ? 5'd1 : rel_num;
  assign w_start_ir = 10'(w_i_eff) * 10'(w_r_eff);
  assign w_empty    = IW'(w_start_ir) > IW'(N);
  assign w_last_j   = (r_j == r_i - 5'd1);
  assign w_start    = (r_state == IDLE) && pe_psum_finish;
  assign w_acc_clr  = w_start || (r_state == WRITE);
  assign w_acc_en   = (r_state == ACC);

  assign psum_rf_addr = r_rf_addr;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_psum[gi] = psum_out[gi*DW +: DW];
    end

    // Each word's (block start, offset-in-group) is derived from its left
    // neighbour, so no divider is needed to map output index -> PE index.
    assign w_blk[0] = r_blk;
    assign w_m[0]   = r_m;
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic          w_wrap;
      logic [DW-1:0] r_acc;
      assign w_wrap       = (w_m[gi] == r_r - 5'd1);
      assign w_blk[gi+1]  = w_wrap ? w_blk[gi] + IW'(r_ir) : w_blk[gi];
      assign w_m[gi+1]    = w_wrap ? 5'd0 : w_m[gi] + 5'd1;
      assign w_idx[gi]    = SW'(w_blk[gi] + r_jr + IW'(w_m[gi]));
      assign w_word[gi]   = w_valid[gi] ? w_psum[w_idx[gi]] : '0;
      assign w_line[gi*DW +: DW] = r_acc;

      always_ff @(posedge clk) begin
        if (reset || w_acc_clr) begin
          r_acc <= '0;
        end else if (w_acc_en) begin
          r_acc <= r_acc + w_word[gi];
        end
      end
    end

    // A word exists only if its whole block of I*R PEs lies inside the array.
    for (gi = 0; gi <= DEPTH; gi++) begin : g_valid
      assign w_valid[gi] = (w_blk[gi] + IW'(r_ir)) <= IW'(N);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (pe_psum_finish) w_state_next = w_empty ? DONE : ACC;
      ACC:     if (w_last_j) w_state_next = WRITE;
      WRITE: begin
        if (w_valid[DEPTH] || (r_rf_addr != '1)) begin
          w_state_next = ACC;
        end else begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i            <= 5'd1;
      r_r            <= 5'd1;
      r_ir           <= 10'd1;
      r_j            <= '0;
      r_jr           <= '0;
      r_blk          <= '0;
      r_m            <= '0;
      r_wp           <= '0;
      r_rf_addr      <= '0;
      su_add_finish  <= 1'b0;
      out_data       <= '0;
      psum_write_en  <= 1'b0;
      psum_BRAM_addr <= '0;
    end else begin
      psum_write_en <= 1'b0;
      su_add_finish <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rf_addr <= '0;
          if (conv_finish) r_wp <= '0;
          if (pe_psum_finish) begin
            r_i   <= w_i_eff;
            r_r   <= w_r_eff;
            r_ir  <= w_start_ir;
            r_j   <= '0;
            r_jr  <= '0;
            r_blk <= '0;
            r_m   <= '0;
          end
        end
        ACC: begin
          r_j  <= r_j + 5'd1;
          r_jr <= r_jr + IW'(r_r);
        end
        WRITE: begin
          out_data       <= w_line;
          psum_write_en  <= 1'b1;
          psum_BRAM_addr <= r_wp;
          r_wp           <= r_wp + 10'd1;
          r_j            <= '0;
          r_jr           <= '0;
          if (w_valid[DEPTH]) begin
            r_blk <= w_blk[DEPTH];
            r_m   <= w_m[DEPTH];
          end else if (r_rf_addr != '1) begin
            r_rf_addr <= r_rf_addr + 1'b1;
            r_blk     <= '0;
            r_m       <= '0;
          end
        end
        DONE: begin
          su_add_finish <= 1'b1;
          r_rf_addr     <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_su_adder_ambi_irrel.sv
// Directed bench for su_adder_ambi_irrel: hand-computed line contents, write
// addresses, write spacing and pass completion timing.
`timescale 1ns/1ps
module tb_su_adder_ambi_irrel;
  logic         clk = 1'b0;
  logic         reset;
  logic [4095:0] psum_out;
  logic         pe_psum_finish, conv_finish;
  logic [4:0]   irrel_num, rel_num;
  logic [1:0]   psum_rf_addr;
  logic         su_add_finish;
  logic [511:0] out_data;
  logic         psum_write_en;
  logic [9:0]   psum_BRAM_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int pat_mode  = 0;
  int rf_offset = 0;
  int logging   = 0;
  int log_n     = 0;
  int su_cnt    = 0;
  int su_rel    = -1;
  logic [511:0] log_data [64];
  int           log_addr [64];
  int           log_rel  [64];

  always #5 clk = ~clk;

  su_adder_ambi_irrel dut (
    .clk(clk), .reset(reset), .psum_out(psum_out),
    .pe_psum_finish(pe_psum_finish), .conv_finish(conv_finish),
    .irrel_num(irrel_num), .rel_num(rel_num), .psum_rf_addr(psum_rf_addr),
    .su_add_finish(su_add_finish), .out_data(out_data),
    .psum_write_en(psum_write_en), .psum_BRAM_addr(psum_BRAM_addr)
  );

  // pattern 0: every psum = 1; pattern 1: psum[i] = i + rf_offset*rf_addr
  always_comb begin
    psum_out = '0;
    for (int i = 0; i < 256; i++) begin
      if (pat_mode == 0) psum_out[i*16 +: 16] = 16'd1;
      else psum_out[i*16 +: 16] = 16'(i + rf_offset * int'(psum_rf_addr));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (logging != 0) begin
      if (psum_write_en === 1'b1 && log_n < 64) begin
        log_data[log_n] = out_data;
        log_addr[log_n] = int'(psum_BRAM_addr);
        log_rel[log_n]  = cyc - start_cyc;
        $display("write %0d: addr=%0d rel_cycle=%0d word0=%0d word31=%0d", log_n,
                 psum_BRAM_addr, cyc - start_cyc, out_data[15:0], out_data[511:496]);
        log_n = log_n + 1;
      end
      if (su_add_finish === 1'b1) begin
        su_cnt = su_cnt + 1;
        su_rel = cyc - start_cyc;
        $display("su_add_finish at rel_cycle=%0d", su_rel);
      end
    end
  end

  function automatic int wd(input int line, input int w);
    logic [511:0] l;
    l = log_data[line];
    return int'(l[w*16 +: 16]);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  task automatic run_pass(input logic [4:0] i_n, input logic [4:0] r_n, input bit clr, input int budget);
    @(negedge clk);
    irrel_num = i_n;
    rel_num   = r_n;
    if (clr) begin
      conv_finish = 1'b1;
      @(negedge clk);
      conv_finish = 1'b0;
    end
    log_n  = 0;
    su_cnt = 0;
    su_rel = -1;
    pe_psum_finish = 1'b1;
    start_cyc = cyc;
    logging = 1;
    @(negedge clk);
    pe_psum_finish = 1'b0;
    for (int k = 0; k < budget && su_cnt == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    logging = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pe_psum_finish = 1'b0;
    conv_finish = 1'b0;
    irrel_num = 5'd1;
    rel_num = 5'd1;
    repeat (3) @(negedge clk);
    n_checks++; if (psum_rf_addr !== 2'd0) begin n_fail++; $display("FAIL reset_rf_addr: got %0d expected 0", psum_rf_addr); end
    n_checks++; if (su_add_finish !== 1'b0) begin n_fail++; $display("FAIL reset_su: got %0b expected 0", su_add_finish); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got nonzero expected 0"); end
    n_checks++; if (psum_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b expected 0", psum_write_en); end
    n_checks++; if (psum_BRAM_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", psum_BRAM_addr); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ones;
    logic [511:0] exp_line;
    pat_mode = 0;
    run_pass(5'd4, 5'd3, 1'b0, 200);
    n_checks++; if (log_n != 8) begin n_fail++; $display("FAIL ones_count: got %0d writes expected 8", log_n); end
    n_checks++; if (su_cnt != 1) begin n_fail++; $display("FAIL ones_su_count: got %0d pulses expected 1", su_cnt); end
    n_checks++; if (su_rel != 42) begin n_fail++; $display("FAIL ones_su_time: got %0d expected 42", su_rel); end
    for (int k = 0; k < 8 && k < log_n; k++) begin
      exp_line = '0;
      for (int w = 0; w < 32; w++) exp_line[w*16 +: 16] = ((k % 2) == 1 && w == 31) ? 16'd0 : 16'd4;
      n_checks++; if (log_addr[k] != k) begin n_fail++; $display("FAIL ones_addr%0d: got %0d expected %0d", k, log_addr[k], k); end
      n_checks++; if (log_rel[k] != 6 + 5*k) begin n_fail++; $display("FAIL ones_time%0d: got %0d expected %0d", k, log_rel[k], 6 + 5*k); end
      n_checks++; if (log_data[k] !== exp_line) begin n_fail++; $display("FAIL ones_line%0d: got w0=%0d w31=%0d expected w0=4 w31=%0d", k, wd(k,0), wd(k,31), (k%2==1) ? 0 : 4); end
    end
  endtask

  task automatic test_back_to_back;
    pat_mode = 0;
    run_pass(5'd4, 5'd3, 1'b0, 200);
    n_checks++; if (log_n != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", log_n); end
    n_checks++; if (log_addr[0] != 8) begin n_fail++; $display("FAIL b2b_first_addr: got %0d expected 8", log_addr[0]); end
    n_checks++; if (log_addr[7] != 15) begin n_fail++; $display("FAIL b2b_last_addr: got %0d expected 15", log_addr[7]); end
    n_checks++; if (wd(0,0) != 4) begin n_fail++; $display("FAIL b2b_word0: got %0d expected 4", wd(0,0)); end
    run_pass(5'd4, 5'd3, 1'b1, 200);
    n_checks++; if (log_addr[0] != 0) begin n_fail++; $display("FAIL conv_first_addr: got %0d expected 0", log_addr[0]); end
    n_checks++; if (log_addr[7] != 7) begin n_fail++; $display("FAIL conv_last_addr: got %0d expected 7", log_addr[7]); end
  endtask

  task automatic test_ramp_i2r1;
    pat_mode = 1; rf_offset = 1000;
    run_pass(5'd2, 5'd1, 1'b1, 300);
    n_checks++; if (log_n != 16) begin n_fail++; $display("FAIL r21_count: got %0d expected 16", log_n); end
    n_checks++; if (wd(0,0) != 1) begin n_fail++; $display("FAIL r21_l0w0: got %0d expected 1", wd(0,0)); end
    n_checks++; if (wd(0,31) != 125) begin n_fail++; $display("FAIL r21_l0w31: got %0d expected 125", wd(0,31)); end
    n_checks++; if (wd(1,0) != 129) begin n_fail++; $display("FAIL r21_l1w0: got %0d expected 129", wd(1,0)); end
    n_checks++; if (wd(3,31) != 509) begin n_fail++; $display("FAIL r21_l3w31: got %0d expected 509", wd(3,31)); end
    n_checks++; if (wd(4,0) != 2001) begin n_fail++; $display("FAIL r21_rf1_w0: got %0d expected 2001", wd(4,0)); end
    n_checks++; if (wd(15,31) != 6509) begin n_fail++; $display("FAIL r21_rf3_w31: got %0d expected 6509", wd(15,31)); end
    n_checks++; if (log_addr[15] != 15) begin n_fail++; $display("FAIL r21_last_addr: got %0d expected 15", log_addr[15]); end
    n_checks++; if (log_rel[15] != 49) begin n_fail++; $display("FAIL r21_last_time: got %0d expected 49", log_rel[15]); end
    n_checks++; if (su_rel != 50) begin n_fail++; $display("FAIL r21_su_time: got %0d expected 50", su_rel); end
  endtask

  task automatic test_ramp_i4r3;
    pat_mode = 1; rf_offset = 0;
    run_pass(5'd4, 5'd3, 1'b1, 200);
    n_checks++; if (log_n != 8) begin n_fail++; $display("FAIL r43_count: got %0d expected 8", log_n); end
    n_checks++; if (wd(0,0) != 18) begin n_fail++; $display("FAIL r43_out0: got %0d expected 18", wd(0,0)); end
    n_checks++; if (wd(0,1) != 22) begin n_fail++; $display("FAIL r43_out1: got %0d expected 22", wd(0,1)); end
    n_checks++; if (wd(0,2) != 26) begin n_fail++; $display("FAIL r43_out2: got %0d expected 26", wd(0,2)); end
    n_checks++; if (wd(0,3) != 66) begin n_fail++; $display("FAIL r43_out3: got %0d expected 66", wd(0,3)); end
    n_checks++; if (wd(0,31) != 502) begin n_fail++; $display("FAIL r43_out31: got %0d expected 502", wd(0,31)); end
    n_checks++; if (wd(1,30) != 986) begin n_fail++; $display("FAIL r43_out62: got %0d expected 986", wd(1,30)); end
    n_checks++; if (wd(1,31) != 0) begin n_fail++; $display("FAIL r43_pad: got %0d expected 0", wd(1,31)); end
  endtask

  task automatic test_zero_as_one;
    pat_mode = 1; rf_offset = 1000;
    run_pass(5'd0, 5'd0, 1'b1, 400);
    n_checks++; if (log_n != 32) begin n_fail++; $display("FAIL z_count: got %0d expected 32", log_n); end
    n_checks++; if (wd(0,5) != 5) begin n_fail++; $display("FAIL z_l0w5: got %0d expected 5", wd(0,5)); end
    n_checks++; if (wd(7,31) != 255) begin n_fail++; $display("FAIL z_l7w31: got %0d expected 255", wd(7,31)); end
    n_checks++; if (wd(8,0) != 1000) begin n_fail++; $display("FAIL z_l8w0: got %0d expected 1000", wd(8,0)); end
    n_checks++; if (wd(31,31) != 3255) begin n_fail++; $display("FAIL z_l31w31: got %0d expected 3255", wd(31,31)); end
    n_checks++; if (log_rel[1] != 5) begin n_fail++; $display("FAIL z_spacing: got %0d expected 5", log_rel[1]); end
    n_checks++; if (su_rel != 66) begin n_fail++; $display("FAIL z_su_time: got %0d expected 66", su_rel); end
  endtask

  task automatic test_exact_fit;
    pat_mode = 1; rf_offset = 0;
    run_pass(5'd16, 5'd16, 1'b1, 200);
    n_checks++; if (log_n != 4) begin n_fail++; $display("FAIL fit_count: got %0d expected 4", log_n); end
    n_checks++; if (wd(0,0) != 1920) begin n_fail++; $display("FAIL fit_w0: got %0d expected 1920", wd(0,0)); end
    n_checks++; if (wd(0,15) != 2160) begin n_fail++; $display("FAIL fit_w15: got %0d expected 2160", wd(0,15)); end
    n_checks++; if (wd(0,16) != 0) begin n_fail++; $display("FAIL fit_w16: got %0d expected 0", wd(0,16)); end
    n_checks++; if (su_rel != 70) begin n_fail++; $display("FAIL fit_su_time: got %0d expected 70", su_rel); end
  endtask

  task automatic test_no_output;
    run_pass(5'd31, 5'd31, 1'b1, 50);
    n_checks++; if (log_n != 0) begin n_fail++; $display("FAIL empty_writes: got %0d expected 0", log_n); end
    n_checks++; if (su_cnt != 1) begin n_fail++; $display("FAIL empty_su_count: got %0d expected 1", su_cnt); end
    n_checks++; if (su_rel != 2) begin n_fail++; $display("FAIL empty_su_time: got %0d expected 2", su_rel); end
  endtask

  task automatic test_reset_mid_pass;
    pat_mode = 1; rf_offset = 0;
    @(negedge clk);
    irrel_num = 5'd4; rel_num = 5'd3;
    pe_psum_finish = 1'b1;
    @(negedge clk);
    pe_psum_finish = 1'b0;
    repeat (13) @(negedge clk);
    n_checks++; if (psum_rf_addr !== 2'd1) begin n_fail++; $display("FAIL mid_rf_addr: got %0d expected 1", psum_rf_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (psum_rf_addr !== 2'd0) begin n_fail++; $display("FAIL mid_reset_rf: got %0d expected 0", psum_rf_addr); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL mid_reset_data: got w0=%0d expected 0", out_data[15:0]); end
    n_checks++; if (psum_BRAM_addr !== 10'd0) begin n_fail++; $display("FAIL mid_reset_addr: got %0d expected 0", psum_BRAM_addr); end
    n_checks++; if (psum_write_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_we: got %0b expected 0", psum_write_en); end
    repeat (3) @(negedge clk);
    n_checks++; if (psum_write_en !== 1'b0 || su_add_finish !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got we=%0b su=%0b expected 0 0", psum_write_en, su_add_finish); end
    run_pass(5'd4, 5'd3, 1'b0, 200);
    n_checks++; if (log_n != 8) begin n_fail++; $display("FAIL restart_count: got %0d expected 8", log_n); end
    n_checks++; if (log_addr[0] != 0) begin n_fail++; $display("FAIL restart_addr: got %0d expected 0", log_addr[0]); end
    n_checks++; if (wd(0,0) != 18) begin n_fail++; $display("FAIL restart_out0: got %0d expected 18", wd(0,0)); end
  endtask

  initial begin
    test_reset;
    test_all_ones;
    test_back_to_back;
    test_ramp_i2r1;
    test_ramp_i4r3;
    test_zero_as_one;
    test_exact_fit;
    test_no_output;
    test_reset_mid_pass;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
